// File: rtl/pointer_sequencer.sv
// Job-level batch controller driving the pointer_array address generator.
// Define PTR_SEQ_PERF_EN to build the stall/busy performance counters.
module pointer_sequencer #(
   parameter int N_UNITS = 4,
   parameter int NOUT_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                job_valid,
   output logic                job_ready,
   input  logic [31:0]         job_base_addr,
   input  logic [7:0]          job_kernel_size,
   input  logic [NOUT_W-1:0]   job_n_outputs,
   input  logic                mac_ready,
   output logic                ptr_load,
   output logic [31:0]         ptr_start_addr,
   output logic [7:0]          ptr_kernel_size,
   output logic [N_UNITS-1:0]  ptr_active_units,
   output logic                ptr_step,
   output logic [NOUT_W-1:0]   batch_idx,
   output logic                batch_last,
   output logic                busy,
   output logic                done,
   output logic [31:0]         perf_stall_cycles,
   output logic [31:0]         perf_busy_cycles
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [31:0]        addr_q;
   logic [7:0]         ksz_q;
   logic [NOUT_W-1:0]  rem_q;
   logic [NOUT_W-1:0]  idx_q;
   logic [7:0]         step_q;
   logic [31:0]        ptr_addr_q;
   logic [7:0]         ptr_ksz_q;
   logic [N_UNITS-1:0] ptr_mask_q;

   logic               accept;
   logic               empty_job;
   logic               rem_small;
   logic               step_last;
   logic [NOUT_W-1:0]  rem_next;
   logic [31:0]        stride;
   logic [31:0]        addr_next;

   function automatic logic [N_UNITS-1:0] unit_mask(
      input logic [NOUT_W-1:0] rem
   );
      logic [N_UNITS-1:0] m;
      m = '0;
      for (int i = 0; i < N_UNITS; i++)
         m[i] = 32'(rem) > 32'(i);
      return m;
   endfunction

   assign accept    = (state_q == S_IDLE) && job_valid;
   assign empty_job = (job_kernel_size == 8'd0) ||
                      (job_n_outputs == '0);
   assign rem_small = 32'(rem_q) <= 32'(N_UNITS);
   assign rem_next  = rem_small ? '0 : rem_q - NOUT_W'(N_UNITS);
   // Kernel size is never zero in RUN, so ksz_q-1 cannot underflow.
   assign step_last = (state_q == S_RUN) && mac_ready &&
                      (step_q == ksz_q - 8'd1);
   assign stride    = 32'(N_UNITS) * {24'd0, ksz_q};
   assign addr_next = addr_q + stride;

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      job_ready = 1'b0;
      ptr_load  = 1'b0;
      ptr_step  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy      = 1'b0;
            job_ready = 1'b1;
            if (job_valid)
               state_d = empty_job ? S_DONE : S_LOAD;
         end
         S_LOAD: begin
            ptr_load = 1'b1;
            state_d  = S_RUN;
         end
         S_RUN: begin
            ptr_step = mac_ready;
            if (step_last)
               state_d = (rem_next != '0) ? S_LOAD : S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= '0;
         ksz_q      <= '0;
         rem_q      <= '0;
         idx_q      <= '0;
         step_q     <= '0;
         ptr_addr_q <= '0;
         ptr_ksz_q  <= '0;
         ptr_mask_q <= '0;
      end else begin
         if (accept) begin
            addr_q <= job_base_addr;
            ksz_q  <= job_kernel_size;
            rem_q  <= job_n_outputs;
            idx_q  <= '0;
            // Pointer outputs only move when a load will follow.
            if (!empty_job) begin
               ptr_addr_q <= job_base_addr;
               ptr_ksz_q  <= job_kernel_size;
               ptr_mask_q <= unit_mask(job_n_outputs);
            end
         end
         if (state_q == S_LOAD)
            step_q <= '0;
         else if (ptr_step)
            step_q <= step_q + 8'd1;
         if (step_last) begin
            rem_q <= rem_next;
            if (rem_next != '0) begin
               addr_q     <= addr_next;
               idx_q      <= idx_q + NOUT_W'(1);
               ptr_addr_q <= addr_next;
               ptr_ksz_q  <= ksz_q;
               ptr_mask_q <= unit_mask(rem_next);
            end
         end
      end
   end

   assign ptr_start_addr   = ptr_addr_q;
   assign ptr_kernel_size  = ptr_ksz_q;
   assign ptr_active_units = ptr_mask_q;
   assign batch_idx        = idx_q;
   assign batch_last       = ((state_q == S_LOAD) ||
                              (state_q == S_RUN)) && rem_small;

`ifdef PTR_SEQ_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         busy_q  <= '0;
      end else if (accept) begin
         stall_q <= '0;
         busy_q  <= '0;
      end else begin
         if ((state_q == S_RUN) && !mac_ready && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
         if (busy && (busy_q != '1))
            busy_q <= busy_q + 32'd1;
      end
   end

   assign perf_stall_cycles = stall_q;
   assign perf_busy_cycles  = busy_q;
`else
   assign perf_stall_cycles = '0;
   assign perf_busy_cycles  = '0;
`endif

endmodule

// File: tb/tb_pointer_sequencer.sv
// Scoreboard bench for pointer_sequencer: expected loads/done events are
// queued per job and matched against the DUT as they occur.
module tb_pointer_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        job_valid;
   logic        job_ready;
   logic [31:0] job_base_addr;
   logic [7:0]  job_kernel_size;
   logic [15:0] job_n_outputs;
   logic        mac_ready;
   logic        ptr_load;
   logic [31:0] ptr_start_addr;
   logic [7:0]  ptr_kernel_size;
   logic [3:0]  ptr_active_units;
   logic        ptr_step;
   logic [15:0] batch_idx;
   logic        batch_last;
   logic        busy;
   logic        done;
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_busy_cycles;

`ifdef PTR_SEQ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct {
      bit          is_done;
      int          cyc;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [7:0]  ksz;
      bit          last;
      int          idx;
      int          prev;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   steps = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pointer_sequencer #(
      .N_UNITS(4),
      .NOUT_W(16)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .job_valid        (job_valid),
      .job_ready        (job_ready),
      .job_base_addr    (job_base_addr),
      .job_kernel_size  (job_kernel_size),
      .job_n_outputs    (job_n_outputs),
      .mac_ready        (mac_ready),
      .ptr_load         (ptr_load),
      .ptr_start_addr   (ptr_start_addr),
      .ptr_kernel_size  (ptr_kernel_size),
      .ptr_active_units (ptr_active_units),
      .ptr_step         (ptr_step),
      .batch_idx        (batch_idx),
      .batch_last       (batch_last),
      .busy             (busy),
      .done             (done),
      .perf_stall_cycles(perf_stall_cycles),
      .perf_busy_cycles (perf_busy_cycles)
   );

   // Scoreboard consumer: pops one expected event per load/done pulse.
   always @(negedge clk) begin : mon
      exp_t e;
      if (ptr_step === 1'b1 || ptr_load === 1'b1) begin
         checks++;
         if ((ptr_step && ptr_load) || (ptr_step && !busy)) begin
            failures++;
            $display("FAIL step_excl cyc=%0d load=%0b step=%0b busy=%0b",
                     cyc, ptr_load, ptr_step, busy);
         end
      end
      if (ptr_load === 1'b1 || done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event cyc=%0d load=%0b done=%0b",
                     cyc, ptr_load, done);
         end else begin
            e = sb.pop_front();
            checks++;
            if (e.is_done != done) begin
               failures++;
               $display("FAIL event_kind cyc=%0d got_done=%0b exp_done=%0b",
                        cyc, done, e.is_done);
            end else begin
               checks++;
               if (cyc != e.cyc) begin
                  failures++;
                  $display("FAIL event_cycle got=%0d exp=%0d done=%0b",
                           cyc, e.cyc, done);
               end
               if (e.prev >= 0) begin
                  checks++;
                  if (steps != e.prev) begin
                     failures++;
                     $display("FAIL step_count cyc=%0d got=%0d exp=%0d",
                              cyc, steps, e.prev);
                  end
               end
               if (!e.is_done) begin
                  checks++;
                  if (ptr_start_addr !== e.addr) begin
                     failures++;
                     $display("FAIL load_addr cyc=%0d got=%h exp=%h",
                              cyc, ptr_start_addr, e.addr);
                  end
                  checks++;
                  if (ptr_active_units !== e.mask) begin
                     failures++;
                     $display("FAIL load_mask cyc=%0d got=%b exp=%b",
                              cyc, ptr_active_units, e.mask);
                  end
                  checks++;
                  if (ptr_kernel_size !== e.ksz) begin
                     failures++;
                     $display("FAIL load_ksz cyc=%0d got=%0d exp=%0d",
                              cyc, ptr_kernel_size, e.ksz);
                  end
                  checks++;
                  if (batch_last !== e.last) begin
                     failures++;
                     $display("FAIL batch_last cyc=%0d got=%0b exp=%0b",
                              cyc, batch_last, e.last);
                  end
                  checks++;
                  if (int'(batch_idx) != e.idx) begin
                     failures++;
                     $display("FAIL batch_idx cyc=%0d got=%0d exp=%0d",
                              cyc, batch_idx, e.idx);
                  end
               end
            end
         end
         steps = 0;
      end else if (rst === 1'b1) begin
         steps = 0;
      end else if (ptr_step === 1'b1) begin
         steps++;
      end
   end

   function automatic void push_job(input logic [31:0] base, input int k,
                                    input int n, input int t0,
                                    input int s0);
      exp_t        e;
      int          rem = n;
      logic [31:0] a = base;
      int          l = t0 + 1;
      int          b = 0;
      int          prev = -1;
      int          endc;
      e.addr = '0; e.mask = '0; e.ksz = '0; e.last = 0; e.idx = 0;
      if (k == 0 || n == 0) begin
         e.is_done = 1; e.cyc = t0 + 1; e.prev = 0;
         sb.push_back(e);
         return;
      end
      while (rem > 0) begin
         e.is_done = 0;
         e.cyc     = l;
         e.addr    = a;
         e.mask    = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
         e.ksz     = 8'(k);
         e.last    = (rem <= 4);
         e.idx     = b;
         e.prev    = prev;
         sb.push_back(e);
         rem  -= (rem > 4) ? 4 : rem;
         endc  = l + k + ((b == 0) ? s0 : 0);
         prev  = k;
         if (rem > 0) begin
            a = a + 32'(4 * k);
            l = endc + 1;
            b++;
         end else begin
            e.is_done = 1;
            e.cyc     = endc + 1;
            e.prev    = k;
            sb.push_back(e);
         end
      end
   endfunction

   task automatic start_job(input logic [31:0] base, input logic [7:0] k,
                            input logic [15:0] n, output int t0);
      bit got = 0;
      t0 = -1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(posedge clk); #1;
         if (job_ready) begin
            job_valid       = 1'b1;
            job_base_addr   = base;
            job_kernel_size = k;
            job_n_outputs   = n;
            t0  = cyc;
            got = 1;
         end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL start_timeout got=not_ready exp=ready");
      end else begin
         @(posedge clk); #1;
         job_valid = 1'b0;
      end
   endtask

   task automatic run_until_idle(input int lo, input int hi);
      bit ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(posedge clk); #1;
         mac_ready = !(cyc >= lo && cyc < hi);
         if (job_ready && sb.size() == 0)
            ok = 1;
      end
      mac_ready = 1'b1;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL run_timeout got=pending%0d exp=pending0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; job_valid = 1'b0; mac_ready = 1'b1;
      job_base_addr = '0; job_kernel_size = '0; job_n_outputs = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({job_ready, ptr_load, ptr_step, done, busy, batch_last} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=100000",
                  {job_ready, ptr_load, ptr_step, done, busy, batch_last});
      end
      checks++;
      if ({ptr_start_addr, ptr_kernel_size, ptr_active_units, batch_idx} !== '0) begin
         failures++;
         $display("FAIL reset_data got=%h/%h/%h/%h exp=0",
                  ptr_start_addr, ptr_kernel_size, ptr_active_units, batch_idx);
      end
      checks++;
      if ({perf_stall_cycles, perf_busy_cycles} !== 64'd0) begin
         failures++;
         $display("FAIL reset_perf got=%0d/%0d exp=0/0",
                  perf_stall_cycles, perf_busy_cycles);
      end
      rst = 1'b0;
   endtask

   task automatic test_two_batch;
      int t0;
      start_job(32'h1000, 8'd8, 16'd6, t0);
      push_job(32'h1000, 8, 6, t0, 0);
      run_until_idle(0, 0);
      checks++;
      if (perf_busy_cycles !== (PERF ? 32'd19 : 32'd0)) begin
         failures++;
         $display("FAIL two_batch_busy got=%0d exp=%0d",
                  perf_busy_cycles, PERF ? 19 : 0);
      end
      checks++;
      if (perf_stall_cycles !== 32'd0) begin
         failures++;
         $display("FAIL two_batch_stall got=%0d exp=0", perf_stall_cycles);
      end
      checks++;
      if (ptr_start_addr !== 32'h1020 || ptr_active_units !== 4'b0011) begin
         failures++;
         $display("FAIL ptr_hold got=%h/%b exp=00001020/0011",
                  ptr_start_addr, ptr_active_units);
      end
   endtask

   task automatic test_stall;
      int t0;
      start_job(32'h1000, 8'd8, 16'd6, t0);
      push_job(32'h1000, 8, 6, t0, 3);
      run_until_idle(t0 + 3, t0 + 6);
      checks++;
      if (perf_stall_cycles !== (PERF ? 32'd3 : 32'd0)) begin
         failures++;
         $display("FAIL stall_count got=%0d exp=%0d",
                  perf_stall_cycles, PERF ? 3 : 0);
      end
      checks++;
      if (perf_busy_cycles !== (PERF ? 32'd22 : 32'd0)) begin
         failures++;
         $display("FAIL stall_busy got=%0d exp=%0d",
                  perf_busy_cycles, PERF ? 22 : 0);
      end
   endtask

   task automatic test_empty;
      int t0;
      start_job(32'h1234, 8'd0, 16'd5, t0);
      push_job(32'h1234, 0, 5, t0, 0);
      run_until_idle(0, 0);
      start_job(32'h5678, 8'd3, 16'd0, t0);
      push_job(32'h5678, 3, 0, t0, 0);
      run_until_idle(0, 0);
      checks++;
      if (perf_busy_cycles !== (PERF ? 32'd1 : 32'd0)) begin
         failures++;
         $display("FAIL empty_busy got=%0d exp=%0d",
                  perf_busy_cycles, PERF ? 1 : 0);
      end
      checks++;
      if (ptr_start_addr !== 32'h1020 || ptr_kernel_size !== 8'd8) begin
         failures++;
         $display("FAIL empty_hold got=%h/%0d exp=00001020/8",
                  ptr_start_addr, ptr_kernel_size);
      end
   endtask

   task automatic test_wrap;
      int t0;
      start_job(32'hFFFF_FFF0, 8'd4, 16'd8, t0);
      push_job(32'hFFFF_FFF0, 4, 8, t0, 0);
      run_until_idle(0, 0);
      checks++;
      if (perf_busy_cycles !== (PERF ? 32'd11 : 32'd0)) begin
         failures++;
         $display("FAIL wrap_busy got=%0d exp=%0d",
                  perf_busy_cycles, PERF ? 11 : 0);
      end
   endtask

   task automatic test_back_to_back;
      int t0;
      start_job(32'h0000_0100, 8'd1, 16'd9, t0);
      push_job(32'h0000_0100, 1, 9, t0, 0);
      run_until_idle(0, 0);
      start_job(32'h0000_0200, 8'd2, 16'd4, t0);
      push_job(32'h0000_0200, 2, 4, t0, 0);
      run_until_idle(0, 0);
      checks++;
      if (busy !== 1'b0 || batch_last !== 1'b0) begin
         failures++;
         $display("FAIL idle_flags got=%b%b exp=00", busy, batch_last);
      end
   endtask

   task automatic test_busy_ignored;
      int ta;
      bit ok = 0;
      start_job(32'h2000, 8'd3, 16'd5, ta);
      push_job(32'h2000, 3, 5, ta, 0);
      push_job(32'h3000, 2, 1, ta + 10, 0);
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk); #1;
         if (cyc == ta + 3) begin
            job_valid       = 1'b1;
            job_base_addr   = 32'h3000;
            job_kernel_size = 8'd2;
            job_n_outputs   = 16'd1;
         end
         if (cyc == ta + 10) begin
            checks++;
            if (job_ready !== 1'b1) begin
               failures++;
               $display("FAIL ready_after_done got=%b exp=1", job_ready);
            end
         end
         if (cyc == ta + 11)
            job_valid = 1'b0;
         if (cyc > ta + 11 && job_ready && sb.size() == 0)
            ok = 1;
      end
      job_valid = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL busy_ign_timeout got=pending%0d exp=pending0", sb.size());
         sb.delete();
      end
      checks++;
      if (perf_busy_cycles !== (PERF ? 32'd4 : 32'd0)) begin
         failures++;
         $display("FAIL busy_ign_perf got=%0d exp=%0d",
                  perf_busy_cycles, PERF ? 4 : 0);
      end
   endtask

   task automatic test_reset_mid_run;
      int t0;
      start_job(32'h4000, 8'd6, 16'd8, t0);
      push_job(32'h4000, 6, 8, t0, 0);
      void'(sb.pop_back());
      for (int i = 0; i < 50 && cyc < t0 + 10; i++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({job_ready, ptr_load, ptr_step, done, busy, batch_last} !== 6'b100000) begin
         failures++;
         $display("FAIL midrst_ctrl got=%b exp=100000",
                  {job_ready, ptr_load, ptr_step, done, busy, batch_last});
      end
      checks++;
      if ({ptr_start_addr, ptr_kernel_size, ptr_active_units, batch_idx} !== '0) begin
         failures++;
         $display("FAIL midrst_data got=%h/%h/%h/%h exp=0",
                  ptr_start_addr, ptr_kernel_size, ptr_active_units, batch_idx);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL midrst_loads got=pending%0d exp=pending0", sb.size());
         sb.delete();
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      start_job(32'h5000, 8'd2, 16'd3, t0);
      push_job(32'h5000, 2, 3, t0, 0);
      run_until_idle(0, 0);
      checks++;
      if (perf_busy_cycles !== (PERF ? 32'd4 : 32'd0)) begin
         failures++;
         $display("FAIL post_rst_busy got=%0d exp=%0d",
                  perf_busy_cycles, PERF ? 4 : 0);
      end
   endtask

   initial begin
      test_reset();
      test_two_batch();
      test_stall();
      test_empty();
      test_wrap();
      test_back_to_back();
      test_busy_ignored();
      test_reset_mid_run();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL leftover got=pending%0d exp=pending0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
